// File: rtl/syn_seg_display_pkg.sv
// Shared definitions for the seven-segment debug display back-end.
//   - view-index constants selecting which CPU debug word is shown
//   - digit count of the display and the all-segments-off pattern
//   - helper locating the most-significant non-zero nibble of a word,
//     used by the optional leading-zero blanking (SEG_DISP_LZ_BLANK_EN)
package syn_seg_display_pkg;

  typedef enum logic [1:0] {
    DISP_MODE_SYS = 2'd0,
    DISP_MODE_PC  = 2'd1,
    DISP_MODE_RF  = 2'd2,
    DISP_MODE_DM  = 2'd3
  } disp_mode_e;

  localparam int          DISP_DIGITS = 8;
  localparam logic [7:0]  SEG_BLANK   = 8'hFF;

  // Index of the highest non-zero nibble; 0 for an all-zero word so that
  // digit 0 is always considered significant.
  function automatic logic [2:0] msn_index(input logic [31:0] word);
    logic [2:0] top;
    top = 3'd0;
    for (int i = 0; i < DISP_DIGITS; i++) begin
      if (word[i*4 +: 4] != 4'h0) top = 3'(i);
    end
    return top;
  endfunction

endpackage

// File: rtl/syn_seg_display_cmb_hex_seg.sv
// cmb_hex_seg: combinational hex nibble to seven-segment decoder.
// Ports:
//   i_nibble  in  4  value 0..F
//   o_seg     out 7  segments g..a, active-low (common-anode display)
module cmb_hex_seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/syn_seg_display.sv
// syn_seg_display: debug display back-end. Shows one of four CPU debug
// words on an 8-digit common-anode seven-segment display, one digit at a
// time. A debounced push-button steps through the views.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   display             view 0 word (syscall display)
//   pc_dbg              view 1 word (program counter)
//   regfile_data_dbg    view 2 word (debug register read)
//   datamem_data_dbg    view 3 word (debug data-memory read)
//   halted              CPU halted flag, lights dp of digit 0
//   btn_mode            raw asynchronous view button, active-high
//   seg                 segments, active-low, [7]=dp, [6:0]=g..a
//   an                  anodes, active-low, an[0]=least-significant nibble
//   mode                current view index
// Build option: define SEG_DISP_LZ_BLANK_EN to blank leading-zero digits.
module syn_seg_display
  import syn_seg_display_pkg::*;
#(
  parameter int ScanDiv        = 100000,
  parameter int DebounceCycles = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] display,
  input  logic [31:0] pc_dbg,
  input  logic [31:0] regfile_data_dbg,
  input  logic [31:0] datamem_data_dbg,
  input  logic        halted,
  input  logic        btn_mode,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [1:0]  mode
);

  localparam int ScanW = (ScanDiv > 2) ? $clog2(ScanDiv) : 1;
  localparam int DbW   = (DebounceCycles > 2) ? $clog2(DebounceCycles) : 1;
  localparam int IdxW  = $clog2(DISP_DIGITS);

  localparam logic [ScanW-1:0] SCAN_LAST = ScanW'(ScanDiv - 1);
  localparam logic [DbW-1:0]   DB_LAST   = DbW'(DebounceCycles - 1);
  localparam logic [IdxW-1:0]  IDX_LAST  = IdxW'(DISP_DIGITS - 1);

  // Button path
  logic           r_sync0;
  logic           r_sync1;
  logic           r_db_level;
  logic           r_db_prev;
  logic [DbW-1:0] r_db_cnt;

  // Scan / latch / view
  logic [ScanW-1:0] r_scan_cnt;
  logic [IdxW-1:0]  r_idx;
  logic [31:0]      r_latch;
  disp_mode_e       r_mode;

  // Output registers
  logic [7:0] r_seg;
  logic [7:0] r_an;

  logic        w_mode_adv;
  logic        w_tick;
  disp_mode_e  w_next_mode;
  disp_mode_e  w_sel_mode;
  logic [31:0] w_sel_word;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg7;
  logic        w_dp;
  logic        w_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= btn_mode;
      r_sync1 <= r_sync0;
    end
  end

  // The counter only runs while the synced level disagrees with the
  // accepted level, so any return to agreement restarts the qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_db_prev <= r_db_level;
      if (r_sync1 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync1;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_mode_adv  = r_db_level & ~r_db_prev;
  assign w_next_mode = disp_mode_e'(r_mode + 2'd1);
  assign w_tick      = (r_scan_cnt == SCAN_LAST);

  // On a view change the latch must load the incoming view's word.
  assign w_sel_mode = w_mode_adv ? w_next_mode : r_mode;

  always_comb begin
    w_sel_word = display;
    case (w_sel_mode)
      DISP_MODE_SYS: w_sel_word = display;
      DISP_MODE_PC:  w_sel_word = pc_dbg;
      DISP_MODE_RF:  w_sel_word = regfile_data_dbg;
      DISP_MODE_DM:  w_sel_word = datamem_data_dbg;
      default:       w_sel_word = display;
    endcase
  end

  // A view change outranks a scan tick: the frame restarts at digit 0.
  // Otherwise the word is only sampled at the frame boundary so a frame
  // never mixes digits of two different words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= DISP_MODE_SYS;
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_latch    <= '0;
    end else if (w_mode_adv) begin
      r_mode     <= w_next_mode;
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_latch    <= w_sel_word;
    end else begin
      if (w_tick) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 1'b1;
        if (r_idx == IDX_LAST) r_latch <= w_sel_word;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  assign w_nibble = r_latch[{r_idx, 2'b00} +: 4];
  assign w_dp     = ~((r_idx == '0) & halted);

`ifdef SEG_DISP_LZ_BLANK_EN
  assign w_blank = (r_idx > msn_index(r_latch));
`else
  assign w_blank = 1'b0;
`endif

  cmb_hex_seg u_hex_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg7)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= 8'hFF;
    end else begin
      r_an  <= ~(8'h01 << r_idx);
      r_seg <= w_blank ? {w_dp, SEG_BLANK[6:0]} : {w_dp, w_seg7};
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign mode = r_mode;

endmodule

// File: tb/tb_syn_seg_display.sv
// Bench for syn_seg_display with ScanDiv=4, DebounceCycles=3.
// Honours SEG_DISP_LZ_BLANK_EN the same way the design does.
module tb_syn_seg_display;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam int FR = 8 * SD;

  logic        clk;
  logic        rst;
  logic [31:0] display;
  logic [31:0] pc_dbg;
  logic [31:0] regfile_data_dbg;
  logic [31:0] datamem_data_dbg;
  logic        halted;
  logic        btn_mode;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [1:0]  mode;

  int n_cmp = 0;
  int n_bad = 0;

  syn_seg_display #(.ScanDiv(SD), .DebounceCycles(DC)) dut (
    .clk              (clk),
    .rst              (rst),
    .display          (display),
    .pc_dbg           (pc_dbg),
    .regfile_data_dbg (regfile_data_dbg),
    .datamem_data_dbg (datamem_data_dbg),
    .halted           (halted),
    .btn_mode         (btn_mode),
    .seg              (seg),
    .an               (an),
    .mode             (mode)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  bit          m_valid = 0;
  int          m_phase;        // cycles into the current frame
  logic [31:0] m_word;         // word shown during this frame
  logic [1:0]  m_mode;
  logic        m_db;           // accepted button level
  logic        m_rise;         // accepted rising edge, acted on next cycle
  logic [DC:0] m_hist;         // raw button samples, [0] newest
  logic [7:0]  exp_seg;
  logic [7:0]  exp_an;
  logic [1:0]  exp_mode;

  function automatic logic [31:0] view_word(input logic [1:0] v);
    case (v)
      2'd0: return display;
      2'd1: return pc_dbg;
      2'd2: return regfile_data_dbg;
      default: return datamem_data_dbg;
    endcase
  endfunction

  function automatic logic [7:0] model_an(input int phase);
    int d;
    d = (phase / SD) % 8;
    return 8'(~(32'd1 << d));
  endfunction

  function automatic logic [7:0] model_seg(input int phase, input logic [31:0] w, input logic halt);
    int   d;
    logic dp;
    d  = (phase / SD) % 8;
    dp = !(d == 0 && halt);
`ifdef SEG_DISP_LZ_BLANK_EN
    begin
      int top;
      top = 0;
      for (int i = 0; i < 8; i++) if (w[i*4 +: 4] != 4'h0) top = i;
      if (d > top) return {dp, 7'h7F};
    end
`endif
    return {dp, hex_tab[w[d*4 +: 4]][6:0]};
  endfunction

  // Outputs after an edge reflect the model state before that edge.
  // The button is accepted once the synchronised samples (raw delayed by
  // two clocks) have disagreed with the accepted level DC times in a row.
  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1;
      m_phase  <= 0;
      m_word   <= '0;
      m_mode   <= 2'd0;
      m_db     <= 1'b0;
      m_rise   <= 1'b0;
      m_hist   <= '0;
      exp_seg  <= 8'hFF;
      exp_an   <= 8'hFF;
      exp_mode <= 2'd0;
    end else begin
      exp_seg <= model_seg(m_phase, m_word, halted);
      exp_an  <= model_an(m_phase);
      m_hist  <= {m_hist[DC-1:0], btn_mode};
      if (m_hist[DC:1] == {DC{~m_db}}) begin
        m_db   <= ~m_db;
        m_rise <= ~m_db;
      end else begin
        m_rise <= 1'b0;
      end
      if (m_rise) begin
        m_mode   <= m_mode + 2'd1;
        exp_mode <= m_mode + 2'd1;
        m_word   <= view_word(m_mode + 2'd1);
        m_phase  <= 0;
      end else begin
        exp_mode <= m_mode;
        if (m_phase == FR - 1) begin
          m_phase <= 0;
          m_word  <= view_word(m_mode);
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check8("model seg", seg, exp_seg);
      check8("model an", an, exp_an);
      check8("model mode", {6'd0, mode}, {6'd0, exp_mode});
    end
  end

  // ---------------- driver tasks ----------------
  // Walks one full frame, pinning every anode value and the first cycle
  // of each digit's segments against hand-computed bytes (byte d = digit d).
  task automatic check_frame(input string name, input logic [63:0] digits, input bit dp0,
                             input int chg_d, input logic [31:0] chg_val);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < SD; c++) begin
        @(negedge clk);
        check8({name, " an"}, an, 8'(~(32'd1 << d)));
        if (c == 0) begin
          check8({name, " seg"}, seg, digits[d*8 +: 8] & ((dp0 && d == 0) ? 8'h7F : 8'hFF));
          if (d == chg_d) display = chg_val;
        end
      end
    end
  endtask

  task automatic press(input int n_high, input int n_low);
    btn_mode = 1'b1;
    repeat (n_high) @(negedge clk);
    btn_mode = 1'b0;
    repeat (n_low) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst              = 1'b1;
    display          = 32'h1234_ABCD;
    pc_dbg           = 32'hCAFE_0007;
    regfile_data_dbg = 32'h0000_0050;
    datamem_data_dbg = 32'h89AB_CDEF;
    halted           = 1'b0;
    btn_mode         = 1'b0;
    repeat (3) @(negedge clk);
    check8("reset seg", seg, 8'hFF);
    check8("reset an", an, 8'hFF);
    check8("reset mode", {6'd0, mode}, 8'd0);
    rst = 1'b0;

    // Frame 0 shows the reset latch (zero); frame 1 the sampled word.
`ifdef SEG_DISP_LZ_BLANK_EN
    check_frame("frame0", 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, -1, '0);
`else
    check_frame("frame0", 64'hC0C0_C0C0_C0C0_C0C0, 1'b0, -1, '0);
`endif
    check_frame("frame1", 64'hF9A4_B099_8883_C6A1, 1'b0, -1, '0);

    halted = 1'b1;
    check_frame("halted", 64'hF9A4_B099_8883_C6A1, 1'b1, -1, '0);
    halted = 1'b0;

    // Word change mid-frame must not disturb the rest of this frame.
    check_frame("midchg", 64'hF9A4_B099_8883_C6A1, 1'b0, 2, 32'h0000_00A5);
`ifdef SEG_DISP_LZ_BLANK_EN
    check_frame("a5", 64'hFFFF_FFFF_FFFF_8892, 1'b0, 3, 32'h0);
    check_frame("zero", 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, -1, '0);
`else
    check_frame("a5", 64'hC0C0_C0C0_C0C0_8892, 1'b0, 3, 32'h0);
    check_frame("zero", 64'hC0C0_C0C0_C0C0_C0C0, 1'b0, -1, '0);
`endif

    // Glitch shorter than the debounce window is ignored.
    press(2, 10);
    check8("glitch mode", {6'd0, mode}, 8'd0);

    // Accepted press: 2 sync + 3 debounce + 1 register = 6 cycles.
    btn_mode = 1'b1;
    repeat (5) @(negedge clk);
    check8("press lat5 mode", {6'd0, mode}, 8'd0);
    @(negedge clk);
    check8("press lat6 mode", {6'd0, mode}, 8'd1);
    btn_mode = 1'b0;
    @(negedge clk);
    check8("pc an", an, 8'hFE);
    check8("pc seg", seg, 8'hF8);
    repeat (12) @(negedge clk);

    press(6, 12);
    check8("press2 mode", {6'd0, mode}, 8'd2);
    press(6, 12);
    check8("press3 mode", {6'd0, mode}, 8'd3);
    press(6, 12);
    check8("press4 mode", {6'd0, mode}, 8'd0);

    // Move to view 1, let it run a while, then reset mid-frame.
    press(6, 45);
    check8("press5 mode", {6'd0, mode}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    check8("midrst seg", seg, 8'hFF);
    check8("midrst an", an, 8'hFF);
    check8("midrst mode", {6'd0, mode}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check8("post rst an", an, 8'hFE);
    check8("post rst seg", seg, 8'hC0);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
